// File: rtl/aes256_key_sched_ctrl.sv
// rtl/aes256_key_sched_ctrl.sv - AES-256 key-expansion sequencer with 15-entry round-key buffer
module aes256_key_sched_ctrl #(
  parameter int KEY_W  = 256,
  parameter int RK_W   = 128,
  parameter int NUM_RK = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  output logic              ready,
  output logic              busy,
  output logic              keys_valid,
  output logic [3:0]        exp_rc,
  output logic [KEY_W-1:0]  exp_key,
  input  logic [KEY_W-1:0]  exp_key_out,
  input  logic [3:0]        rk_rd_idx,
  output logic [RK_W-1:0]   rk_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               keys_valid_q, keys_valid_d;
  logic [3:0]         exp_rc_q, exp_rc_d;
  logic [KEY_W-1:0]   exp_key_q, exp_key_d;
  logic [RK_W-1:0]    rk_q [NUM_RK];
  logic [RK_W-1:0]    rk_d [NUM_RK];
  logic [RK_W-1:0]    rk_rd_data_q, rk_rd_data_d;

  // Even/odd slot written by the current iteration: rc=i fills rk[2i] and rk[2i+1].
  logic [3:0]         even_slot, odd_slot;

  assign even_slot = {exp_rc_q[2:0], 1'b0};
  assign odd_slot  = {exp_rc_q[2:0], 1'b1};

  assign ready      = (state_q != S_EXPAND);
  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;
  assign exp_rc     = exp_rc_q;
  assign exp_key    = exp_key_q;
  assign rk_rd_data = rk_rd_data_q;

  // Next-state logic: accept a key, step the expansion core once per cycle, serve reads.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    keys_valid_d = keys_valid_q;
    exp_rc_d     = exp_rc_q;
    exp_key_d    = exp_key_q;
    rk_d         = rk_q;
    rk_rd_data_d = '0;

    // Read sees the pre-write contents; index 15 has no entry and returns zero.
    for (int k = 0; k < NUM_RK; k++) begin
      if (k[3:0] == rk_rd_idx) begin
        rk_rd_data_d = rk_q[k];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          exp_key_d    = key_in;
          rk_d[0]      = key_in[KEY_W-1:RK_W];
          rk_d[1]      = key_in[RK_W-1:0];
          exp_rc_d     = 4'd1;
          keys_valid_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_EXPAND;
        end
      end
      S_EXPAND: begin
        for (int k = 0; k < NUM_RK; k++) begin
          if (k[3:0] == even_slot) begin
            rk_d[k] = exp_key_out[KEY_W-1:RK_W];
          end
        end
        if (exp_rc_q == 4'd7) begin
          // Last iteration: the low half would be rk[15], which AES-256 never uses.
          exp_rc_d     = 4'd0;
          busy_d       = 1'b0;
          keys_valid_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          for (int k = 0; k < NUM_RK; k++) begin
            if (k[3:0] == odd_slot) begin
              rk_d[k] = exp_key_out[RK_W-1:0];
            end
          end
          exp_key_d = exp_key_out;
          exp_rc_d  = exp_rc_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      exp_rc_q     <= 4'd0;
      exp_key_q    <= '0;
      rk_q         <= '{default: '0};
      rk_rd_data_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      keys_valid_q <= keys_valid_d;
      exp_rc_q     <= exp_rc_d;
      exp_key_q    <= exp_key_d;
      rk_q         <= rk_d;
      rk_rd_data_q <= rk_rd_data_d;
    end
  end

endmodule

// File: doc/aes256_key_sched_ctrl.md
# aes256_key_sched_ctrl

Sequences the combinational AES-256 key-expansion core over seven iterations and buffers all fifteen 128-bit round keys. The decrypt datapath can then read any round key by index, typically 14 down to 0. It sits between the key-load interface and the inverse-cipher round engine, and owns the round-constant index and the expansion core's working key.

## Interface
- KEY_W, 256, cipher key width; only 256 supported
- RK_W, 128, round-key width; only 128 supported
- NUM_RK, 15, number of stored round keys; only 15 supported
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request to expand key_in; accepted when start && ready
- key_in  in  256  cipher key; sampled only on the accept edge
- ready  out  1  combinational; 1 in IDLE and DONE, 0 in EXPAND
- busy  out  1  registered; 1 while in EXPAND
- keys_valid  out  1  registered; 1 in DONE, meaning all 15 round keys are stored
- exp_rc  out  4  round-constant index to the expansion core; registered; 0 outside EXPAND
- exp_key  out  256  working key to the expansion core; registered
- exp_key_out  in  256  expansion core result; combinational function of exp_rc and exp_key
- rk_rd_idx  in  4  round-key read index
- rk_rd_data  out  128  round key at rk_rd_idx; registered, 1-cycle latency

## Operation
- States: IDLE (reset state), EXPAND, DONE.
- Accept (IDLE or DONE, start=1):
  - exp_key <= key_in; rk[0] <= key_in[255:128]; rk[1] <= key_in[127:0].
  - exp_rc <= 1; keys_valid <= 0; busy <= 1; go to EXPAND.
- EXPAND, each cycle with exp_rc = i (1..7):
  - rk[2i] <= exp_key_out[255:128].
  - If i < 7: rk[2i+1] <= exp_key_out[127:0]; exp_key <= exp_key_out; exp_rc <= i+1.
  - If i = 7: exp_key_out[127:0] is discarded (no rk[15]); exp_rc <= 0; busy <= 0; keys_valid <= 1; go to DONE.
- start during EXPAND is ignored (ready=0); no queuing.
- DONE holds keys until the next accept. Start in DONE restarts, and keys_valid drops on the accept edge.
- Read port: rk_rd_data <= rk[rk_rd_idx] every cycle, in any state. Index 15 returns 0. Data read while keys_valid=0 is undefined for the consumer but deterministic (stale or reset value).
- exp_key_out is never registered except as described above. The core is purely combinational, so no extra wait states.

## Timing
- Reset (async assert, any state, including mid-EXPAND):
  - State IDLE; busy, keys_valid, exp_rc, exp_key and rk_rd_data = 0.
  - All rk[0..14] = 0.
  - ready = 1 immediately.
- Deassertion is synchronous to clk in the integrating design. The first accept is possible on the first rising edge after rst_n is high.
- Accept at edge E:
  - busy=1 and exp_rc=1 from E.
  - Keys rk[2],rk[3] written at E+1, ..., rk[14] written at E+7.
  - keys_valid=1 and busy=0 after E+7, i.e. 8 edges from accept to done.
- First valid read: rk_rd_idx presented in the cycle after E+7; data appears after the next edge.
- A read of index k in the same cycle as its write returns the old value; the new value is visible one cycle later.
- exp_rc advances exactly once per EXPAND cycle, 1 to 7 without gaps. It never exceeds 7.

## Test plan
- FIPS-197 C.3 key 000102…1f accepted -> after 8 edges keys_valid=1; reads show rk[0]=000102…0f, rk[1]=101112…1f, rk[2]=a573c29fa176c498a97fce93a572c09c, rk[14]=24fc79ccbf0979e9371ac23c6d68de36.
- Monitor the core interface during EXPAND -> exp_rc sequence 1,2,…,7 on consecutive cycles and then 0; exp_key equals the previous exp_key_out (checked against a reference model).
- start pulsed at E+3 with a different key -> ignored; final keys match the first key; ready=0 on E..E+6.
- rst_n asserted at E+4 -> immediately busy=0, keys_valid=0, exp_rc=0, rk[*]=0. A new accept then completes normally in 8 edges.
- Restart from DONE with key all-ones -> keys_valid low for 8 edges; all 15 keys match the model.
- Read rk_rd_idx=15 and sweep 14→0 -> idx 15 returns 0; each key appears exactly 1 cycle after its index.
